cpu_top: RTL and testbench

- Minimal 8-bit CPU: 256-byte unified memory, 16×8-bit register file, 16-bit instructions with a 4-bit opcode, four memory-mapped PWM outputs, one interrupt input with acknowledge.
- Top of the processor hierarchy; a bench preloads memory through the hierarchical path memory.memory[0..255].

---
 rtl/isa_pkg.sv | 52 +++++
 rtl/cpu_top_memory.sv | 23 ++
 rtl/cpu_top.sv | 183 ++++++++++++++++++
 tb/tb_cpu_top.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 8-bit CPU: opcodes, control states, fixed addresses
// and the register-to-register ALU.
package isa_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_LOAD  = 4'h1,
        OP_STORE = 4'h2,
        OP_MOVI  = 4'h3,
        OP_ADD   = 4'h4,
        OP_SUB   = 4'h5,
        OP_AND   = 4'h6,
        OP_OR    = 4'h7,
        OP_XOR   = 4'h8,
        OP_JMP   = 4'h9,
        OP_JZ    = 4'hA,
        OP_RETI  = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        ST_FETCH0    = 2'd0,
        ST_FETCH1    = 2'd1,
        ST_EXEC      = 2'd2,
        ST_INT_ENTRY = 2'd3
    } state_e;

    localparam logic [7:0] ISR_ADDR_DEFAULT = 8'h80;
    localparam logic [7:0] PWM_BASE_DEFAULT = 8'hFC;

    // Reserved and unknown opcodes fall through to zero; callers ignore the result for them.
    function automatic logic [7:0] alu_op(input logic [3:0] op,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] res;
        res = '0;
        case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            default: res = '0;
        endcase
        return res;
    endfunction

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_XOR);
    endfunction

endpackage

// File: rtl/cpu_top_memory.sv
// 256-byte unified code/data memory: one combinational read port, one synchronous write port.
module cpu_top_memory
    import isa_pkg::*;
(
    input  logic       clk,
    input  logic [7:0] i_raddr,
    output logic [7:0] o_rdata,
    input  logic       i_we,
    input  logic [7:0] i_waddr,
    input  logic [7:0] i_wdata
);

    logic [7:0] memory [0:255];

    assign o_rdata = memory[i_raddr];

    always_ff @(posedge clk) begin
        if (i_we) begin
            memory[i_waddr] <= i_wdata;
        end
    end

endmodule

// File: rtl/cpu_top.sv
// Minimal non-pipelined 8-bit CPU: 3-cycle fetch/fetch/execute, one edge-triggered
// interrupt with a single save slot, and four memory-mapped PWM channels.
module cpu_top
    import isa_pkg::*;
#(
    parameter logic [7:0] ISR_ADDR = ISR_ADDR_DEFAULT,
    parameter logic [7:0] PWM_BASE = PWM_BASE_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    output logic pwm_out0,
    output logic pwm_out1,
    output logic pwm_out2,
    output logic pwm_out3,
    input  logic int_req,
    output logic int_ack
);

    state_e     r_state;
    logic [7:0] r_pc;
    logic [7:0] r_ir_hi;
    logic [7:0] r_ir_lo;
    logic [7:0] r_regs [0:15];
    logic       r_z;
    logic       r_ie;
    logic       r_pending;
    logic [7:0] r_saved_pc;
    logic       r_saved_z;
    logic       r_int_ack;
    logic       r_req;
    logic       r_req_d;
    logic [7:0] r_duty [0:3];
    logic [7:0] r_pwm_cnt;
    logic [3:0] r_pwm;

    logic [3:0] w_op;
    logic [3:0] w_rd;
    logic [7:0] w_a;
    logic [7:0] w_b;
    logic [7:0] w_alu;
    logic [7:0] w_raddr;
    logic [7:0] w_rdata;
    logic       w_we;
    logic [7:0] w_pwm_off;
    logic       w_pwm_hit;
    logic       w_edge;
    logic       w_take;

    assign w_op      = r_ir_hi[7:4];
    assign w_rd      = r_ir_hi[3:0];
    assign w_a       = r_regs[r_ir_lo[7:4]];
    assign w_b       = r_regs[r_ir_lo[3:0]];
    assign w_alu     = alu_op(w_op, w_a, w_b);
    assign w_pwm_off = r_ir_lo - PWM_BASE;
    assign w_pwm_hit = (w_pwm_off < 8'd4);
    assign w_edge    = r_req & ~r_req_d;

    // RETI re-enables interrupts in the same EXEC, so an edge caught during the ISR
    // is taken immediately after it instead of one instruction later.
    assign w_take = (r_pending | w_edge) & (r_ie | (w_op == OP_RETI));

    assign w_we = !reset_n && (r_state == ST_EXEC) && (w_op == OP_STORE);

    always_comb begin
        w_raddr = r_ir_lo;
        case (r_state)
            ST_FETCH0: w_raddr = r_pc;
            ST_FETCH1: w_raddr = r_pc + 8'd1;
            default:   w_raddr = r_ir_lo;
        endcase
    end

    cpu_top_memory memory (
        .clk     (clk),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata),
        .i_we    (w_we),
        .i_waddr (r_ir_lo),
        .i_wdata (r_regs[w_rd])
    );

    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_state    <= ST_FETCH0;
            r_pc       <= '0;
            r_ir_hi    <= '0;
            r_ir_lo    <= '0;
            r_regs     <= '{default: '0};
            r_z        <= 1'b0;
            r_ie       <= 1'b1;
            r_pending  <= 1'b0;
            r_saved_pc <= '0;
            r_saved_z  <= 1'b0;
            r_int_ack  <= 1'b0;
            r_req      <= 1'b0;
            r_req_d    <= 1'b0;
            r_duty     <= '{default: '0};
        end else begin
            r_req     <= int_req;
            r_req_d   <= r_req;
            r_int_ack <= 1'b0;
            if (w_edge) begin
                r_pending <= 1'b1;
            end

            case (r_state)
                ST_FETCH0: begin
                    r_ir_hi <= w_rdata;
                    r_state <= ST_FETCH1;
                end
                ST_FETCH1: begin
                    r_ir_lo <= w_rdata;
                    r_pc    <= r_pc + 8'd2;
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    case (w_op)
                        OP_LOAD: begin
                            r_regs[w_rd] <= w_rdata;
                            r_z          <= (w_rdata == '0);
                        end
                        OP_STORE: begin
                            if (w_pwm_hit) begin
                                r_duty[w_pwm_off[1:0]] <= r_regs[w_rd];
                            end
                        end
                        OP_MOVI: r_regs[w_rd] <= r_ir_lo;
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                            r_regs[w_rd] <= w_alu;
                            r_z          <= (w_alu == '0);
                        end
                        OP_JMP: r_pc <= r_ir_lo;
                        OP_JZ: begin
                            if (r_z) begin
                                r_pc <= r_ir_lo;
                            end
                        end
                        OP_RETI: begin
                            r_pc <= r_saved_pc;
                            r_z  <= r_saved_z;
                            r_ie <= 1'b1;
                        end
                        default: ;
                    endcase
                    if (w_take) begin
                        r_state   <= ST_INT_ENTRY;
                        r_int_ack <= 1'b1;
                    end else begin
                        r_state <= ST_FETCH0;
                    end
                end
                ST_INT_ENTRY: begin
                    r_saved_pc <= r_pc;
                    r_saved_z  <= r_z;
                    r_pc       <= ISR_ADDR;
                    r_ie       <= 1'b0;
                    // A fresh edge landing on the entry cycle must survive the clear.
                    r_pending  <= w_edge;
                    r_state    <= ST_FETCH0;
                end
                default: r_state <= ST_FETCH0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_pwm_cnt <= '0;
            r_pwm     <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
            r_pwm     <= {(r_pwm_cnt < r_duty[3]), (r_pwm_cnt < r_duty[2]),
                          (r_pwm_cnt < r_duty[1]), (r_pwm_cnt < r_duty[0])};
        end
    end

    assign pwm_out0 = r_pwm[0];
    assign pwm_out1 = r_pwm[1];
    assign pwm_out2 = r_pwm[2];
    assign pwm_out3 = r_pwm[3];
    assign int_ack  = r_int_ack;

endmodule

// File: tb/tb_cpu_top.sv
// Self-checking bench for cpu_top: table-driven ALU/memory programs plus interrupt,
// reset and PWM sequences, with expected fetch addresses kept in a scoreboard queue.
module tb_cpu_top;
    import isa_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic int_req = 1'b0;
    logic pwm_out0, pwm_out1, pwm_out2, pwm_out3, int_ack;

    int n_checks = 0;
    int n_errors = 0;

    cpu_top #(.ISR_ADDR(8'h80), .PWM_BASE(8'hFC)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .pwm_out0 (pwm_out0),
        .pwm_out1 (pwm_out1),
        .pwm_out2 (pwm_out2),
        .pwm_out3 (pwm_out3),
        .int_req  (int_req),
        .int_ack  (int_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] i0, i1, i2;
        logic [3:0]  rsel;
        logic [7:0]  exp_val;
        logic        exp_z;
        logic        chk_mem;
        logic [7:0]  mem_addr;
        logic [7:0]  mem_val;
    } vec_t;

    typedef struct {
        string      name;
        logic [3:0] rsel;
        logic [7:0] val;
        logic       z;
    } exp_t;

    vec_t       vecs [10];
    exp_t       sbq [$];
    logic [7:0] fetchq [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] c, input logic [3:0] r, input logic [7:0] v,
                                input logic z, input logic cm, input logic [7:0] ma,
                                input logic [7:0] mv);
        vec_t t;
        t.name = n; t.i0 = a; t.i1 = b; t.i2 = c; t.rsel = r; t.exp_val = v; t.exp_z = z;
        t.chk_mem = cm; t.mem_addr = ma; t.mem_val = mv;
        return t;
    endfunction

    task automatic clear_mem();
        for (int a = 0; a < 256; a++) dut.memory.memory[a] = 8'h00;
    endtask

    task automatic put(input logic [7:0] addr, input logic [15:0] ins);
        logic [7:0] a1;
        a1 = addr + 8'd1;
        dut.memory.memory[addr] = ins[15:8];
        dut.memory.memory[a1]   = ins[7:0];
    endtask

    // Reset is held while memory is (re)loaded; returns just after release.
    task automatic start_from_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b0;
    endtask

    task automatic check_fetch(input string name, input int max_cyc);
        int cyc;
        logic [7:0] e;
        cyc = 0;
        while (fetchq.size() > 0 && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            if (dut.r_state == ST_FETCH0) begin
                e = fetchq.pop_front();
                check(name, dut.r_pc, e);
            end
        end
        check({name, "_timeout"}, fetchq.size(), 0);
        fetchq.delete();
    endtask

    task automatic watch_acks(input int ncyc, output int cnt, output int first);
        cnt = 0;
        first = -1;
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            if (int_ack) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
    endtask

    task automatic load_isr();
        reset_n = 1'b1;
        int_req = 1'b0;
        clear_mem();
        put(8'h80, 16'h0000);
        put(8'h82, 16'hF000);
    endtask

    initial begin
        exp_t e;
        int   cnt, first, hi0, hi1, hi2, hi3, cyc;

        vecs[0] = mk("sub_zero", 16'h3105, 16'h3205, 16'h5312, 4'd3, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00);
        vecs[1] = mk("add_wrap", 16'h31FF, 16'h3201, 16'h4312, 4'd3, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00);
        vecs[2] = mk("and",      16'h31F0, 16'h323C, 16'h6412, 4'd4, 8'h30, 1'b0, 1'b0, 8'h00, 8'h00);
        vecs[3] = mk("or",       16'h31F0, 16'h323C, 16'h7512, 4'd5, 8'hFC, 1'b0, 1'b0, 8'h00, 8'h00);
        vecs[4] = mk("xor",      16'h31F0, 16'h323C, 16'h8612, 4'd6, 8'hCC, 1'b0, 1'b0, 8'h00, 8'h00);
        vecs[5] = mk("sub_wrap", 16'h31F0, 16'h323C, 16'h5721, 4'd7, 8'h4C, 1'b0, 1'b0, 8'h00, 8'h00);
        vecs[6] = mk("movi_noz", 16'h3100, 16'h3200, 16'h3300, 4'd3, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        vecs[7] = mk("reserved", 16'h3107, 16'hB1FF, 16'hE1AA, 4'd1, 8'h07, 1'b0, 1'b0, 8'h00, 8'h00);
        vecs[8] = mk("ld_st",    16'h34A5, 16'h2430, 16'h1530, 4'd5, 8'hA5, 1'b0, 1'b1, 8'h30, 8'hA5);
        vecs[9] = mk("ld_zero",  16'h3101, 16'h1540, 16'h0000, 4'd5, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00);

        for (int k = 0; k < 10; k++) begin
            reset_n = 1'b1;
            clear_mem();
            put(8'h00, vecs[k].i0);
            put(8'h02, vecs[k].i1);
            put(8'h04, vecs[k].i2);
            sbq.push_back('{vecs[k].name, vecs[k].rsel, vecs[k].exp_val, vecs[k].exp_z});
            start_from_reset();
            repeat (12) @(posedge clk);
            @(negedge clk);
            e = sbq.pop_front();
            check({e.name, "_reg"}, dut.r_regs[e.rsel], e.val);
            check({e.name, "_z"}, dut.r_z, e.z);
            if (vecs[k].chk_mem)
                check({e.name, "_mem"}, dut.memory.memory[vecs[k].mem_addr], vecs[k].mem_val);
        end

        // JZ taken after a zero SUB, landing on a self-loop at 40
        reset_n = 1'b1;
        clear_mem();
        put(8'h00, 16'h3105); put(8'h02, 16'h3205); put(8'h04, 16'h5312); put(8'h06, 16'hA040);
        put(8'h40, 16'h9040);
        fetchq = '{8'h00, 8'h02, 8'h04, 8'h06, 8'h40, 8'h40};
        start_from_reset();
        check_fetch("jz_taken", 40);

        // JZ not taken when Z=0
        reset_n = 1'b1;
        clear_mem();
        put(8'h00, 16'h3101); put(8'h02, 16'h3202); put(8'h04, 16'h5312); put(8'h06, 16'hA040);
        put(8'h08, 16'h9008);
        fetchq = '{8'h00, 8'h02, 8'h04, 8'h06, 8'h08, 8'h08};
        start_from_reset();
        check_fetch("jz_not_taken", 40);

        // pc wraps FE -> 00 after fetching the last instruction slot
        reset_n = 1'b1;
        clear_mem();
        put(8'h00, 16'h90FE); put(8'hFE, 16'h3977);
        fetchq = '{8'h00, 8'hFE, 8'h00, 8'hFE};
        start_from_reset();
        check_fetch("pc_wrap", 30);
        check("pc_wrap_r9", dut.r_regs[9], 8'h77);

        // ISR round trip
        load_isr();
        fetchq = '{8'h00, 8'h02, 8'h04, 8'h80, 8'h82, 8'h06, 8'h08};
        start_from_reset();
        fork
            begin repeat (5) @(posedge clk); #1 int_req = 1'b1; repeat (5) @(posedge clk); #1 int_req = 1'b0; end
            watch_acks(60, cnt, first);
            check_fetch("isr_fetch", 60);
        join
        check("isr_ack_count", cnt, 1);
        check("isr_latency_ok", (first > 0) && (first - 6 <= 5), 1'b1);
        check("isr_ie_restored", dut.r_ie, 1'b1);

        // Level held for 40 cycles produces a single acknowledge
        load_isr();
        fetchq = '{8'h00, 8'h02, 8'h04, 8'h80, 8'h82, 8'h06};
        start_from_reset();
        fork
            begin repeat (5) @(posedge clk); #1 int_req = 1'b1; repeat (40) @(posedge clk); #1 int_req = 1'b0; end
            watch_acks(80, cnt, first);
            check_fetch("held_fetch", 60);
        join
        check("held_ack_count", cnt, 1);

        // Second pulse inside the ISR is taken straight after RETI
        load_isr();
        fetchq = '{8'h00, 8'h02, 8'h04, 8'h80, 8'h82, 8'h80, 8'h82, 8'h06};
        start_from_reset();
        fork
            begin
                repeat (5) @(posedge clk); #1 int_req = 1'b1;
                repeat (3) @(posedge clk); #1 int_req = 1'b0;
                repeat (3) @(posedge clk); #1 int_req = 1'b1;
                repeat (2) @(posedge clk); #1 int_req = 1'b0;
            end
            watch_acks(60, cnt, first);
            check_fetch("nested_fetch", 60);
        join
        check("nested_ack_count", cnt, 2);

        // Reset in the middle of the ISR
        load_isr();
        start_from_reset();
        repeat (5) @(posedge clk); #1 int_req = 1'b1;
        repeat (2) @(posedge clk); #1 int_req = 1'b0;
        cyc = 0;
        while (!int_ack && cyc < 20) begin @(negedge clk); cyc++; end
        check("midisr_ack_seen", int_ack, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("midisr_pc_in_isr", (dut.r_pc >= 8'h80) && (dut.r_pc <= 8'h83), 1'b1);
        check("midisr_ie_clear", dut.r_ie, 1'b0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midisr_rst_pc", dut.r_pc, 8'h00);
        check("midisr_rst_ie", dut.r_ie, 1'b1);
        check("midisr_rst_ack", int_ack, 1'b0);
        check("midisr_rst_state", dut.r_state, ST_FETCH0);
        fetchq = '{8'h00, 8'h02, 8'h80, 8'h82, 8'h04};
        @(posedge clk); #1 reset_n = 1'b0;
        fork
            begin repeat (4) @(posedge clk); #1 int_req = 1'b1; repeat (3) @(posedge clk); #1 int_req = 1'b0; end
            watch_acks(40, cnt, first);
            check_fetch("midisr_refetch", 40);
        join
        check("midisr_reack_count", cnt, 1);

        // PWM duty cycles
        reset_n = 1'b1;
        clear_mem();
        put(8'h00, 16'h3140); put(8'h02, 16'h21FC); put(8'h04, 16'h32FF); put(8'h06, 16'h22FF);
        put(8'h08, 16'h9008);
        start_from_reset();
        repeat (30) @(posedge clk);
        hi0 = 0; hi1 = 0; hi2 = 0; hi3 = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            hi0 += int'(pwm_out0); hi1 += int'(pwm_out1);
            hi2 += int'(pwm_out2); hi3 += int'(pwm_out3);
        end
        check("pwm0_high", hi0, 64);
        check("pwm1_high", hi1, 0);
        check("pwm2_high", hi2, 0);
        check("pwm3_high", hi3, 255);
        check("pwm_mem_fc", dut.memory.memory[8'hFC], 8'h40);
        check("pwm_mem_ff", dut.memory.memory[8'hFF], 8'hFF);

        // Reset state after a busy run
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pc", dut.r_pc, 8'h00);
        check("rst_z", dut.r_z, 1'b0);
        check("rst_ie", dut.r_ie, 1'b1);
        check("rst_pending", dut.r_pending, 1'b0);
        check("rst_saved_pc", dut.r_saved_pc, 8'h00);
        check("rst_ack", int_ack, 1'b0);
        check("rst_state", dut.r_state, ST_FETCH0);
        check("rst_pwm", {pwm_out3, pwm_out2, pwm_out1, pwm_out0}, 4'h0);
        check("rst_duty0", dut.r_duty[0], 8'h00);
        check("rst_duty3", dut.r_duty[3], 8'h00);
        for (int r = 0; r < 16; r++) check($sformatf("rst_r%0d", r), dut.r_regs[r], 8'h00);
        check("rst_mem_kept", dut.memory.memory[8'hFC], 8'h40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
